multiplier_fp_pipe: RTL and testbench
=====================================

// Module: multiplier_fp_pipe
// PURPOSE
//  Pipelined, parametrised IEEE-754-style floating-point multiplier.
//  Successor to the combinational FP8 multiplier: generic exponent/mantissa widths,
//  round-to-nearest-even, valid/ready handshake, exception flags and a sideband tag.
//  Three register stages; significand product uses multiplier_nbit_full (IMPL_TYPE passed through).
// PARAMETERS
//  EXP_W      3   exponent field width (>=2); bias = 2**(EXP_W-1)-1
//  MAN_W      4   stored mantissa width (>=1); significand = MAN_W+1 bits
//  ID_W       4   sideband tag width, carried unchanged with each operation
//  IMPL_TYPE  0   multiplier_nbit_full architecture select
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   1           operand pair valid
//  in_ready   out  1           pipeline accepts operands this cycle
//  in_a       in   1+EXP_W+MAN_W  operand A {sign,exp,man}
//  in_b       in   1+EXP_W+MAN_W  operand B
//  in_id      in   ID_W        tag for this operation
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts result
//  out_result out  1+EXP_W+MAN_W  product
//  out_id     out  ID_W        tag of this result
//  out_flags  out  4           {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: clk and rst only; synchronous, active-high. All stage valid bits cleared;
//   out_valid=0, out_result=0, out_id=0, out_flags=0; in_ready=1 from the cycle after reset.
//   Reset mid-operation discards all in-flight data; no result emerges for it.
//  Handshake: adv = out_ready | ~out_valid; in_ready = adv (combinational).
//   All three stages shift together when adv=1; hold all stage registers when adv=0.
//   Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   Bubbles are not collapsed. Latency exactly 3 cycles with no stall; throughput 1/cycle.
//   out_result, out_id, out_flags held stable while out_valid & ~out_ready.
//  Stage 1: unpack and classify.
//   exp == all-ones: man!=0 -> NaN; else Inf. exp==0 -> zero (DAZ: subnormals read as zero).
//   sign = sa^sb. esum = ea+eb-bias, signed, EXP_W+2 bits.
//  Stage 2: P = {1,ma}*{1,mb}, 2*MAN_W+2 bits.
//  Stage 3: normalise, round and pack.
//   If P msb is set, shift right 1 and esum+1.
//   RNE: guard = first bit below LSB, sticky = OR of the rest; round up if guard & (sticky | LSB).
//   Mantissa carry-out renormalises: esum+1, mantissa=0.
//   inexact = guard|sticky for finite nonzero results.
//  Result priority:
//   1 NaN in, or 0*Inf: {sign, all-ones, all-ones}; invalid=1.
//   2 Inf operand (other nonzero): {sign, all-ones, 0}; no flags.
//   3 zero operand: {sign, 0, 0}; no flags.
//   4 final exp >= 2**EXP_W-1: {sign, all-ones, 0}; overflow=1, inexact=1.
//   5 final exp <= 0: FTZ {sign, 0, 0}; underflow=1, inexact=1.
//   6 otherwise normal {sign, exp[EXP_W-1:0], man}.
// TESTING (defaults; E3M4, bias 3)
//  T1 0x30*0x30 (1.0*1.0) -> 0x30, flags 0; out_valid exactly 3 cycles after accept.
//  T2 0x38*0x38 (1.5*1.5) -> 0x42 (2.25); 0x31*0x38 -> 0x3A, inexact=1 (tie to even).
//  T3 0x6F*0x6F -> 0x70, overflow+inexact; 0x10*0x10 -> 0x00, underflow+inexact.
//  T4 0x70*0x00 -> 0x7F, invalid=1; 0xF0*0x30 -> 0xF0; 0x80*0x30 -> 0x80; 0x05*0x30 -> 0x00 (DAZ).
//  T5 Stream 8 ops, ids 0..7, with random out_ready stalls -> results in order, ids match,
//     outputs stable during stall, no loss or duplication.
//  T6 rst during 3 in-flight ops -> out_valid=0 next cycle, none emerge;
//     a new op after reset returns correctly.

Source files
------------

// File: rtl/multiplier_fp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : multiplier_fp_pipe (with helper multiplier_nbit_full)
//  Brief    : Three-stage pipelined floating-point multiplier, RNE rounding,
//             DAZ/FTZ, valid/ready handshake, exception flags, sideband tag.
//  Revision : 1.0 - initial release
// ============================================================================

module multiplier_nbit_full #(
    parameter int N         = 5,
    parameter int IMPL_TYPE = 0
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_p
);
    generate
        if (IMPL_TYPE == 0) begin : g_behav
            assign o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};
        end else begin : g_shift_add
            always_comb begin
                o_p = '0;
                for (int i = 0; i < N; i++) begin
                    if (i_b[i]) o_p = o_p + ({{N{1'b0}}, i_a} << i);
                end
            end
        end
    endgenerate
endmodule

module multiplier_fp_pipe #(
    parameter int EXP_W     = 3,
    parameter int MAN_W     = 4,
    parameter int ID_W      = 4,
    parameter int IMPL_TYPE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [ID_W-1:0]          in_id,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [ID_W-1:0]          out_id,
    output logic [3:0]               out_flags
);
    localparam int c_w   = 1 + EXP_W + MAN_W;
    localparam int c_sig = MAN_W + 1;
    localparam int c_pw  = 2 * MAN_W + 2;
    localparam int c_ew  = EXP_W + 2;
    localparam logic [c_ew-1:0] c_bias    = c_ew'(2**(EXP_W-1) - 1);
    localparam logic [c_ew-1:0] c_exp_max = c_ew'(2**EXP_W - 1);

    logic w_adv;
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    // ---------------- stage 1: unpack and classify ----------------
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic             w_inv, w_inf, w_zero;
    logic [c_ew-1:0]  w_esum;

    assign w_ea     = in_a[c_w-2 -: EXP_W];
    assign w_eb     = in_b[c_w-2 -: EXP_W];
    assign w_ma     = in_a[MAN_W-1:0];
    assign w_mb     = in_b[MAN_W-1:0];
    assign w_nan_a  = (&w_ea) & (|w_ma);
    assign w_nan_b  = (&w_eb) & (|w_mb);
    assign w_inf_a  = (&w_ea) & ~(|w_ma);
    assign w_inf_b  = (&w_eb) & ~(|w_mb);
    assign w_zero_a = ~(|w_ea);
    assign w_zero_b = ~(|w_eb);
    assign w_inv    = w_nan_a | w_nan_b | (w_zero_a & w_inf_b) | (w_inf_a & w_zero_b);
    assign w_inf    = (w_inf_a | w_inf_b) & ~w_inv;
    assign w_zero   = (w_zero_a | w_zero_b) & ~w_inv;
    assign w_esum   = {2'b00, w_ea} + {2'b00, w_eb} - c_bias;

    logic             r_s1_valid, r_s1_sign, r_s1_inv, r_s1_inf, r_s1_zero;
    logic [ID_W-1:0]  r_s1_id;
    logic [c_ew-1:0]  r_s1_esum;
    logic [c_sig-1:0] r_s1_siga, r_s1_sigb;

    // ---------------- stage 2: significand product ----------------
    logic [c_pw-1:0] w_prod;

    multiplier_nbit_full #(
        .N         (c_sig),
        .IMPL_TYPE (IMPL_TYPE)
    ) u_sig_mul (
        .i_a (r_s1_siga),
        .i_b (r_s1_sigb),
        .o_p (w_prod)
    );

    logic            r_s2_valid, r_s2_sign, r_s2_inv, r_s2_inf, r_s2_zero;
    logic [ID_W-1:0] r_s2_id;
    logic [c_ew-1:0] r_s2_esum;
    logic [c_pw-1:0] r_s2_prod;

    // ---------------- stage 3: normalise, round, pack ----------------
    logic             w_msb, w_guard, w_sticky, w_rnd_up, w_ovf, w_unf;
    logic [c_pw-2:0]  w_pn;
    logic [MAN_W-1:0] w_man;
    logic [MAN_W:0]   w_man_r;
    logic [c_ew-1:0]  w_exp_f;
    logic [c_w-1:0]   w_res;
    logic [3:0]       w_flags;

    // Leading one dropped: w_pn holds the fraction bits below the hidden bit.
    assign w_msb    = r_s2_prod[c_pw-1];
    assign w_pn     = w_msb ? r_s2_prod[c_pw-2:0] : {r_s2_prod[c_pw-3:0], 1'b0};
    assign w_man    = w_pn[c_pw-2 -: MAN_W];
    assign w_guard  = w_pn[MAN_W];
    assign w_sticky = |w_pn[MAN_W-1:0];
    assign w_rnd_up = w_guard & (w_sticky | w_man[0]);
    assign w_man_r  = {1'b0, w_man} + {{MAN_W{1'b0}}, w_rnd_up};
    // On mantissa carry-out the low bits are already zero.
    assign w_exp_f  = r_s2_esum + {{(c_ew-1){1'b0}}, w_msb} + {{(c_ew-1){1'b0}}, w_man_r[MAN_W]};
    assign w_ovf    = ~w_exp_f[c_ew-1] & (w_exp_f >= c_exp_max);
    assign w_unf    = w_exp_f[c_ew-1] | (w_exp_f == '0);

    always_comb begin
        w_res   = '0;
        w_flags = 4'b0000;
        if (r_s2_inv) begin
            w_res   = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            w_flags = 4'b1000;
        end else if (r_s2_inf) begin
            w_res   = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (r_s2_zero) begin
            w_res   = {r_s2_sign, {(c_w-1){1'b0}}};
        end else if (w_ovf) begin
            w_res   = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = 4'b0101;
        end else if (w_unf) begin
            w_res   = {r_s2_sign, {(c_w-1){1'b0}}};
            w_flags = 4'b0011;
        end else begin
            w_res   = {r_s2_sign, w_exp_f[EXP_W-1:0], w_man_r[MAN_W-1:0]};
            w_flags = {3'b000, w_guard | w_sticky};
        end
    end

    logic             r_out_valid;
    logic [c_w-1:0]   r_out_result;
    logic [ID_W-1:0]  r_out_id;
    logic [3:0]       r_out_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_id     <= '0;
            r_out_flags  <= '0;
        end else if (w_adv) begin
            r_s1_valid   <= in_valid;
            r_s1_id      <= in_id;
            r_s1_sign    <= in_a[c_w-1] ^ in_b[c_w-1];
            r_s1_inv     <= w_inv;
            r_s1_inf     <= w_inf;
            r_s1_zero    <= w_zero;
            r_s1_esum    <= w_esum;
            r_s1_siga    <= {1'b1, w_ma};
            r_s1_sigb    <= {1'b1, w_mb};

            r_s2_valid   <= r_s1_valid;
            r_s2_id      <= r_s1_id;
            r_s2_sign    <= r_s1_sign;
            r_s2_inv     <= r_s1_inv;
            r_s2_inf     <= r_s1_inf;
            r_s2_zero    <= r_s1_zero;
            r_s2_esum    <= r_s1_esum;
            r_s2_prod    <= w_prod;

            r_out_valid  <= r_s2_valid;
            r_out_result <= w_res;
            r_out_id     <= r_s2_id;
            r_out_flags  <= w_flags;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_id     = r_out_id;
    assign out_flags  = r_out_flags;
endmodule

`default_nettype wire

// File: tb/tb_multiplier_fp_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiplier_fp_pipe
//  Brief    : Self-checking bench for multiplier_fp_pipe (E3M4) against an
//             arithmetic reference model, with directed and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_fp_pipe;
    localparam int E    = 3;
    localparam int M    = 4;
    localparam int IDW  = 4;
    localparam int EMAX = (1 << E) - 1;
    localparam int BIAS = (1 << (E - 1)) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [7:0]     in_a = '0;
    logic [7:0]     in_b = '0;
    logic [IDW-1:0] in_id = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [7:0]     out_result;
    logic [IDW-1:0] out_id;
    logic [3:0]     out_flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]     res;
        logic [IDW-1:0] id;
        logic [3:0]     flags;
    } exp_t;
    exp_t exp_q[$];

    multiplier_fp_pipe #(
        .EXP_W(E), .MAN_W(M), .ID_W(IDW), .IMPL_TYPE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_id(in_id),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_id(out_id), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    // Exact product of the two significands, then round-to-nearest-even to M bits.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b);
        int s, ea, eb, ma, mb, q, pos, e, sh, kept, rem, half;
        logic nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        logic [3:0] fl;
        logic [7:0] r;
        s  = int'(a[7] ^ b[7]);
        ea = int'(a[6:4]); eb = int'(b[6:4]);
        ma = int'(a[3:0]); mb = int'(b[3:0]);
        nan_a = (ea == EMAX) && (ma != 0); nan_b = (eb == EMAX) && (mb != 0);
        inf_a = (ea == EMAX) && (ma == 0); inf_b = (eb == EMAX) && (mb == 0);
        z_a = (ea == 0); z_b = (eb == 0);
        fl = 4'b0000;
        if (nan_a || nan_b || (z_a && inf_b) || (inf_a && z_b)) begin
            r = 8'((s << 7) | 127); fl = 4'b1000;
        end else if (inf_a || inf_b) begin
            r = 8'((s << 7) | (EMAX << M));
        end else if (z_a || z_b) begin
            r = 8'(s << 7);
        end else begin
            q = ((1 << M) + ma) * ((1 << M) + mb);
            pos = 0;
            for (int i = 0; i < 31; i++) if (q[i]) pos = i;
            e    = ea + eb - BIAS + (pos - 2 * M);
            sh   = pos - M;
            kept = q >> sh;
            rem  = q - (kept << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (kept % 2) == 1)) kept = kept + 1;
            if (kept == (1 << (M + 1))) begin
                kept = kept >> 1;
                e = e + 1;
            end
            if (e >= EMAX) begin
                r = 8'((s << 7) | (EMAX << M)); fl = 4'b0101;
            end else if (e <= 0) begin
                r = 8'(s << 7); fl = 4'b0011;
            end else begin
                r  = 8'((s << 7) | (e << M) | (kept - (1 << M)));
                fl = {3'b000, rem != 0};
            end
        end
        return {fl, r};
    endfunction

    // Single compare process: every valid output cycle is checked against the oldest expectation.
    always @(negedge clk) begin
        logic [11:0] m;
        exp_t x;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_out: got out_valid=1 res=%h id=%h, need no output", out_result, out_id);
                end else begin
                    x = exp_q[0];
                    if (out_result !== x.res || out_id !== x.id || out_flags !== x.flags) begin
                        bad++;
                        $display("FAIL stream_result: got res=%h id=%h flags=%b, need res=%h id=%h flags=%b",
                                 out_result, out_id, out_flags, x.res, x.id, x.flags);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                m = model(in_a, in_b);
                x.res = m[7:0]; x.flags = m[11:8]; x.id = in_id;
                exp_q.push_back(x);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %h, need %h", name, got, need);
        end
    endtask

    task automatic directed(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] res, input logic [3:0] fl);
        logic [11:0] m;
        logic [IDW-1:0] id;
        m  = model(a, b);
        check({"model_", name}, {20'd0, m}, {20'd0, fl, res});
        id = IDW'($urandom);
        @(posedge clk); #1;
        out_ready = 1'b1; in_a = a; in_b = b; in_id = id; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({"lat1_", name}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({"lat2_", name}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({"dut_", name}, {15'd0, out_valid, IDW'(out_id), out_flags, out_result},
                              {15'd0, 1'b1, id, fl, res});
    endtask

    task automatic stream(input int nops, input bit seq_ids, input int ready_pct, input int valid_pct);
        int  sent = 0;
        int  cyc  = 0;
        bit  have = 0;
        while (sent < nops && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom_range(99) < ready_pct);
            if (!have) begin
                if ($urandom_range(99) < valid_pct) begin
                    in_a = 8'($urandom); in_b = 8'($urandom);
                    in_id = seq_ids ? IDW'(sent) : IDW'($urandom);
                    in_valid = 1'b1; have = 1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                have = 0;
                sent++;
            end
        end
        check("stream_issue", sent, nops);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("stream_drain", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {24'd0, out_result}, 32'd0);
        check("rst_out_id", {28'd0, out_id}, 32'd0);
        check("rst_out_flags", {28'd0, out_flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        directed("one_x_one", 8'h30, 8'h30, 8'h30, 4'b0000);
        directed("1p5_sq",    8'h38, 8'h38, 8'h42, 4'b0000);
        directed("tie_even",  8'h31, 8'h38, 8'h3A, 4'b0001);
        directed("overflow",  8'h6F, 8'h6F, 8'h70, 4'b0101);
        directed("underflow", 8'h10, 8'h10, 8'h00, 4'b0011);
        directed("inf_x_0",   8'h70, 8'h00, 8'h7F, 4'b1000);
        directed("neg_inf",   8'hF0, 8'h30, 8'hF0, 4'b0000);
        directed("neg_zero",  8'h80, 8'h30, 8'h80, 4'b0000);
        directed("daz",       8'h05, 8'h30, 8'h00, 4'b0000);
        directed("nan_in",    8'h71, 8'hB8, 8'hFF, 4'b1000);

        stream(8, 1'b1, 60, 100);
        stream(300, 1'b0, 70, 80);
        stream(60, 1'b0, 100, 100);

        // Reset with three operations in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 8'h38; in_b = 8'h38; in_id = IDW'(k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("flush_valid0", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("flush_none", {31'd0, out_valid}, 32'd0);
        end
        directed("after_rst", 8'h38, 8'h38, 8'h42, 4'b0000);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
